// File: rtl/filtro_promedio_ventana.sv
// filtro_promedio_ventana
// Mean filter for a 3x3 or 5x5 pixel neighbourhood. A window is captured in
// one cycle, its taps are summed serially, and the sum is divided by N^2 with
// a fixed-point reciprocal multiply. The result is offered on a valid/ack
// handshake and held until it is accepted.
module filtro_promedio_ventana #(
    parameter int ANCHO_PIXEL = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             tamano_mascara,
    input  logic                   ventana_valida,
    input  logic [ANCHO_PIXEL-1:0] pixel_1,
    input  logic [ANCHO_PIXEL-1:0] pixel_2,
    input  logic [ANCHO_PIXEL-1:0] pixel_3,
    input  logic [ANCHO_PIXEL-1:0] pixel_4,
    input  logic [ANCHO_PIXEL-1:0] pixel_5,
    input  logic [ANCHO_PIXEL-1:0] pixel_6,
    input  logic [ANCHO_PIXEL-1:0] pixel_7,
    input  logic [ANCHO_PIXEL-1:0] pixel_8,
    input  logic [ANCHO_PIXEL-1:0] pixel_9,
    input  logic [ANCHO_PIXEL-1:0] pixel_10,
    input  logic [ANCHO_PIXEL-1:0] pixel_11,
    input  logic [ANCHO_PIXEL-1:0] pixel_12,
    input  logic [ANCHO_PIXEL-1:0] pixel_13,
    input  logic [ANCHO_PIXEL-1:0] pixel_14,
    input  logic [ANCHO_PIXEL-1:0] pixel_15,
    input  logic [ANCHO_PIXEL-1:0] pixel_16,
    input  logic [ANCHO_PIXEL-1:0] pixel_17,
    input  logic [ANCHO_PIXEL-1:0] pixel_18,
    input  logic [ANCHO_PIXEL-1:0] pixel_19,
    input  logic [ANCHO_PIXEL-1:0] pixel_20,
    input  logic [ANCHO_PIXEL-1:0] pixel_21,
    input  logic [ANCHO_PIXEL-1:0] pixel_22,
    input  logic [ANCHO_PIXEL-1:0] pixel_23,
    input  logic [ANCHO_PIXEL-1:0] pixel_24,
    input  logic [ANCHO_PIXEL-1:0] pixel_25,
    output logic                   siguiente_ventana,
    output logic [ANCHO_PIXEL-1:0] pixel_salida,
    output logic                   pixel_valido,
    input  logic                   pixel_leido,
    output logic                   ocupado
);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        ACUMULAR = 2'd1,
        ESCALAR  = 2'd2,
        ENTREGAR = 2'd3
    } estado_t;

    // Reciprocals of 9 and 25 scaled by 2^18; slightly above the exact value
    // so that floor() of the product matches floor(sum/N^2) for every sum
    // reachable with 8-bit pixels.
    localparam logic [27:0] RECIPROCO_3X3 = 28'd29128;
    localparam logic [27:0] RECIPROCO_5X5 = 28'd10486;

    estado_t                r_estado;
    estado_t                w_estado_sig;
    logic                   w_captura;
    logic                   w_ultimo_tap;

    logic [ANCHO_PIXEL-1:0] w_entrada [0:24];
    logic [ANCHO_PIXEL-1:0] r_pixeles [0:24];
    logic                   r_es_5x5;
    logic [12:0]            r_suma;
    logic [4:0]             r_contador;
    logic [ANCHO_PIXEL-1:0] r_pixel_salida;
    logic                   r_pixel_valido;
    logic                   r_siguiente;

    // Multiply the accumulated sum by the reciprocal of N^2 and drop the 18
    // fractional bits; the integer part always fits in one pixel.
    function automatic logic [ANCHO_PIXEL-1:0] escalar(
        input logic [12:0] suma,
        input logic        es_5x5
    );
        logic [27:0] reciproco;
        reciproco = es_5x5 ? RECIPROCO_5X5 : RECIPROCO_3X3;
        return ANCHO_PIXEL'((28'(suma) * reciproco) >> 18);
    endfunction

    // Row-major view of the incoming window so capture can be a loop.
    assign w_entrada[0]  = pixel_1;
    assign w_entrada[1]  = pixel_2;
    assign w_entrada[2]  = pixel_3;
    assign w_entrada[3]  = pixel_4;
    assign w_entrada[4]  = pixel_5;
    assign w_entrada[5]  = pixel_6;
    assign w_entrada[6]  = pixel_7;
    assign w_entrada[7]  = pixel_8;
    assign w_entrada[8]  = pixel_9;
    assign w_entrada[9]  = pixel_10;
    assign w_entrada[10] = pixel_11;
    assign w_entrada[11] = pixel_12;
    assign w_entrada[12] = pixel_13;
    assign w_entrada[13] = pixel_14;
    assign w_entrada[14] = pixel_15;
    assign w_entrada[15] = pixel_16;
    assign w_entrada[16] = pixel_17;
    assign w_entrada[17] = pixel_18;
    assign w_entrada[18] = pixel_19;
    assign w_entrada[19] = pixel_20;
    assign w_entrada[20] = pixel_21;
    assign w_entrada[21] = pixel_22;
    assign w_entrada[22] = pixel_23;
    assign w_entrada[23] = pixel_24;
    assign w_entrada[24] = pixel_25;

    // The tap being added this cycle is the last one of the window.
    assign w_ultimo_tap = (r_contador == (r_es_5x5 ? 5'd24 : 5'd8));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= REPOSO;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next-state decode and the busy flag derived from the current state.
    always_comb begin
        w_estado_sig = r_estado;
        w_captura    = 1'b0;
        ocupado      = (r_estado != REPOSO);
        case (r_estado)
            REPOSO: begin
                if (ventana_valida) begin
                    w_captura    = 1'b1;
                    w_estado_sig = ACUMULAR;
                end
            end
            ACUMULAR: begin
                if (w_ultimo_tap) begin
                    w_estado_sig = ESCALAR;
                end
            end
            ESCALAR: begin
                w_estado_sig = ENTREGAR;
            end
            ENTREGAR: begin
                if (pixel_leido) begin
                    w_estado_sig = REPOSO;
                end
            end
            default: begin
                w_estado_sig = REPOSO;
            end
        endcase
    end

    // Window snapshot; later changes on the pixel and size inputs must not
    // disturb the window already being processed.
    always_ff @(posedge clk) begin
        if (w_captura && !reset) begin
            for (int k = 0; k < 25; k++) begin
                r_pixeles[k] <= w_entrada[k];
            end
            r_es_5x5 <= (tamano_mascara == 3'd5);
        end
    end

    // Serial accumulation, scaling and output handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_suma         <= '0;
            r_contador     <= '0;
            r_pixel_salida <= '0;
            r_pixel_valido <= 1'b0;
            r_siguiente    <= 1'b0;
        end else begin
            r_siguiente <= w_captura;
            case (r_estado)
                REPOSO: begin
                    if (w_captura) begin
                        r_suma     <= '0;
                        r_contador <= '0;
                    end
                end
                ACUMULAR: begin
                    r_suma     <= r_suma + 13'(r_pixeles[r_contador]);
                    r_contador <= r_contador + 5'd1;
                end
                ESCALAR: begin
                    r_pixel_salida <= escalar(r_suma, r_es_5x5);
                    r_pixel_valido <= 1'b1;
                end
                ENTREGAR: begin
                    if (pixel_leido) begin
                        r_pixel_valido <= 1'b0;
                    end
                end
                default: begin
                    r_pixel_valido <= 1'b0;
                end
            endcase
        end
    end

    assign siguiente_ventana = r_siguiente;
    assign pixel_salida      = r_pixel_salida;
    assign pixel_valido      = r_pixel_valido;

endmodule
